// File: rtl/pwm_bridge_monitor_pkg.sv
// Shared power-stage definitions: default measurement width, saturation
// constant and the bridge cycle state enumeration used by the bridge
// generator and the bridge monitor.
package pwm_bridge_monitor_pkg;

  localparam int unsigned CNT_W = 21;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    WAIT_A = 3'd0,
    A_ON   = 3'd1,
    GAP_AB = 3'd2,
    B_ON   = 3'd3,
    GAP_BA = 3'd4
  } pwr_state_e;

endpackage

// File: rtl/pwm_in_sync.sv
// Multi-flop synchronizer for one asynchronous PWM input.
//   clk, rst : rising-edge clock, synchronous active-high reset (flops -> 0)
//   d        : asynchronous input
//   q        : input delayed through SYNC_STAGES flops
module pwm_in_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pwm_bridge_monitor.sv
// Half-bridge gate-drive monitor: measures A-high, A->B deadtime, B-high,
// B->A deadtime and period of each complete PWM cycle, and flags
// shoot-through (A and B both high) and stalls (no edge within timeout).
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   pwmA, pwmB      : asynchronous high/low-side gate drives
//   timeout         : stall limit in clk cycles, 0 disables
//   flt_clr         : clears the sticky fault flags
//   a_high..period  : last complete cycle's measurements
//   meas_valid      : one-cycle pulse when measurements update
//   overlap_flt     : sticky shoot-through flag
//   stall_flt       : sticky stall flag
module pwm_bridge_monitor
  import pwm_bridge_monitor_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = pwm_bridge_monitor_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwmA,
  input  logic             pwmB,
  input  logic [CNT_W-1:0] timeout,
  input  logic             flt_clr,
  output logic [CNT_W-1:0] a_high,
  output logic [CNT_W-1:0] dt_ab,
  output logic [CNT_W-1:0] b_high,
  output logic [CNT_W-1:0] dt_ba,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             overlap_flt,
  output logic             stall_flt
);

  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + 1'b1;
  endfunction

  logic s_a, s_b;

  pwm_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk(clk), .rst(rst), .d(pwmA), .q(s_a)
  );
  pwm_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk(clk), .rst(rst), .d(pwmB), .q(s_b)
  );

  // Edge-detect register pair: {B, A} current and previous level.
  logic [1:0] lvl_q, lvl_d, lvl_prev_q, lvl_prev_d;
  logic a_rise, a_fall, b_rise, b_fall, any_edge, both_high;

  always_comb begin
    lvl_d      = {s_b, s_a};
    lvl_prev_d = lvl_q;
    a_rise     =  lvl_q[0] & ~lvl_prev_q[0];
    a_fall     = ~lvl_q[0] &  lvl_prev_q[0];
    b_rise     =  lvl_q[1] & ~lvl_prev_q[1];
    b_fall     = ~lvl_q[1] &  lvl_prev_q[1];
    any_edge   = |(lvl_q ^ lvl_prev_q);
    both_high  = &lvl_q;
  end

  // Stall counter: cycles since last edge; hit fires once on reaching timeout.
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_hit;

  always_comb begin
    stall_cnt_d = any_edge ? '0 : sat_inc(stall_cnt_q);
    stall_hit   = (timeout != '0) && (stall_cnt_d == timeout);
  end

  pwr_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (both_high || stall_hit) begin
      state_d = WAIT_A;
    end else begin
      unique case (state_q)
        WAIT_A: if (a_rise) state_d = A_ON;
        A_ON:   if (a_fall) state_d = GAP_AB;
        GAP_AB: begin
          if (a_rise)      state_d = A_ON;
          else if (b_rise) state_d = B_ON;
        end
        B_ON:   if (b_fall) state_d = GAP_BA;
        GAP_BA: if (a_rise) state_d = A_ON;
        default: state_d = WAIT_A;
      endcase
    end
  end

  logic start_cycle, cycle_done;

  always_comb begin
    start_cycle = (state_d == A_ON) && (state_q != A_ON);
    cycle_done  = start_cycle && (state_q == GAP_BA);
  end

  logic [CNT_W-1:0] a_on_cnt_q, gap_ab_cnt_q, b_on_cnt_q, gap_ba_cnt_q;
  logic [CNT_W-1:0] a_on_cnt_d, gap_ab_cnt_d, b_on_cnt_d, gap_ba_cnt_d;

  always_comb begin
    a_on_cnt_d   = a_on_cnt_q;
    gap_ab_cnt_d = gap_ab_cnt_q;
    b_on_cnt_d   = b_on_cnt_q;
    gap_ba_cnt_d = gap_ba_cnt_q;
    if (start_cycle) begin
      a_on_cnt_d   = CNT_W'(1);
      gap_ab_cnt_d = '0;
      b_on_cnt_d   = '0;
      gap_ba_cnt_d = '0;
    end else begin
      unique case (state_d)
        A_ON:    a_on_cnt_d   = sat_inc(a_on_cnt_q);
        GAP_AB:  gap_ab_cnt_d = sat_inc(gap_ab_cnt_q);
        B_ON:    b_on_cnt_d   = sat_inc(b_on_cnt_q);
        GAP_BA:  gap_ba_cnt_d = sat_inc(gap_ba_cnt_q);
        default: ;
      endcase
    end
  end

  logic [CNT_W-1:0] a_high_q, dt_ab_q, b_high_q, dt_ba_q, period_q;
  logic [CNT_W-1:0] a_high_d, dt_ab_d, b_high_d, dt_ba_d, period_d;
  logic             meas_valid_q, meas_valid_d;
  logic             overlap_q, overlap_d, stall_flt_q, stall_flt_d;
  logic [CNT_W+1:0] cycle_sum;

  always_comb begin
    cycle_sum = (CNT_W+2)'(a_on_cnt_q) + (CNT_W+2)'(gap_ab_cnt_q)
              + (CNT_W+2)'(b_on_cnt_q) + (CNT_W+2)'(gap_ba_cnt_q);
    a_high_d     = a_high_q;
    dt_ab_d      = dt_ab_q;
    b_high_d     = b_high_q;
    dt_ba_d      = dt_ba_q;
    period_d     = period_q;
    meas_valid_d = cycle_done;
    if (cycle_done) begin
      a_high_d = a_on_cnt_q;
      dt_ab_d  = gap_ab_cnt_q;
      b_high_d = b_on_cnt_q;
      dt_ba_d  = gap_ba_cnt_q;
      period_d = (cycle_sum > (CNT_W+2)'(CNT_SAT)) ? CNT_SAT : cycle_sum[CNT_W-1:0];
    end
    // A fault setting in the same cycle as flt_clr wins.
    overlap_d   = (overlap_q   & ~flt_clr) | both_high;
    stall_flt_d = (stall_flt_q & ~flt_clr) | stall_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q        <= '0;
      lvl_prev_q   <= '0;
      stall_cnt_q  <= '0;
      state_q      <= WAIT_A;
      a_on_cnt_q   <= '0;
      gap_ab_cnt_q <= '0;
      b_on_cnt_q   <= '0;
      gap_ba_cnt_q <= '0;
      a_high_q     <= '0;
      dt_ab_q      <= '0;
      b_high_q     <= '0;
      dt_ba_q      <= '0;
      period_q     <= '0;
      meas_valid_q <= 1'b0;
      overlap_q    <= 1'b0;
      stall_flt_q  <= 1'b0;
    end else begin
      lvl_q        <= lvl_d;
      lvl_prev_q   <= lvl_prev_d;
      stall_cnt_q  <= stall_cnt_d;
      state_q      <= state_d;
      a_on_cnt_q   <= a_on_cnt_d;
      gap_ab_cnt_q <= gap_ab_cnt_d;
      b_on_cnt_q   <= b_on_cnt_d;
      gap_ba_cnt_q <= gap_ba_cnt_d;
      a_high_q     <= a_high_d;
      dt_ab_q      <= dt_ab_d;
      b_high_q     <= b_high_d;
      dt_ba_q      <= dt_ba_d;
      period_q     <= period_d;
      meas_valid_q <= meas_valid_d;
      overlap_q    <= overlap_d;
      stall_flt_q  <= stall_flt_d;
    end
  end

  assign a_high      = a_high_q;
  assign dt_ab       = dt_ab_q;
  assign b_high      = b_high_q;
  assign dt_ba       = dt_ba_q;
  assign period      = period_q;
  assign meas_valid  = meas_valid_q;
  assign overlap_flt = overlap_q;
  assign stall_flt   = stall_flt_q;

endmodule

// File: tb/tb_pwm_bridge_monitor.sv
// Self-checking bench for pwm_bridge_monitor. A timestamp-based model
// predicts every output each cycle; directed checks pin key values.
// CNT_W is reduced to 12 so the saturation case stays short.
module tb_pwm_bridge_monitor;

  localparam int W    = 12;
  localparam int MAXV = (1 << W) - 1;
  localparam int LAT  = 3; // SYNC_STAGES + edge-detect register

  logic         clk = 1'b0;
  logic         rst, pwmA, pwmB, flt_clr;
  logic [W-1:0] timeout;
  logic [W-1:0] a_high, dt_ab, b_high, dt_ba, period;
  logic         meas_valid, overlap_flt, stall_flt;

  pwm_bridge_monitor #(.SYNC_STAGES(2), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .pwmA(pwmA), .pwmB(pwmB), .timeout(timeout),
    .flt_clr(flt_clr), .a_high(a_high), .dt_ab(dt_ab), .b_high(b_high),
    .dt_ba(dt_ba), .period(period), .meas_valid(meas_valid),
    .overlap_flt(overlap_flt), .stall_flt(stall_flt)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // ---------------- behavioural model ----------------
  logic [1:0] dq[$];
  logic [1:0] m_prev, cur;
  bit   ready = 0;
  int   phase;   // ordered events seen in current cycle: 0 none, 1 A rose, 2 A fell, 3 B rose, 4 B fell
  int   t_ar, t_af, t_br, t_bf, t_last;
  int   e_ah, e_dab, e_bh, e_dba, e_per;
  bit   e_mv, e_ov, e_st;

  function automatic int clip(input int x);
    return (x > MAXV) ? MAXV : x;
  endfunction

  always @(posedge clk) begin
    bit ar, af, br, bf, both, stl;
    int s;
    cyc = cyc + 1;
    if (rst) begin
      dq.delete();
      repeat (LAT) dq.push_back(2'b00);
      m_prev = 2'b00; phase = 0; t_last = cyc;
      e_ah = 0; e_dab = 0; e_bh = 0; e_dba = 0; e_per = 0;
      e_mv = 0; e_ov = 0; e_st = 0;
      ready = 1;
    end else if (ready) begin
      dq.push_back({pwmB, pwmA});
      cur  = dq.pop_front();
      ar   =  cur[0] & ~m_prev[0];
      af   = ~cur[0] &  m_prev[0];
      br   =  cur[1] & ~m_prev[1];
      bf   = ~cur[1] &  m_prev[1];
      both = cur[0] & cur[1];
      if (cur != m_prev) t_last = cyc;
      stl  = (timeout != 0) && ((cyc - t_last) == int'(timeout));
      e_mv = 0;
      if (both || stl) begin
        phase = 0;
      end else if (ar && (phase == 0 || phase == 2 || phase == 4)) begin
        if (phase == 4) begin
          e_ah  = clip(t_af - t_ar);
          e_dab = clip(t_br - t_af);
          e_bh  = clip(t_bf - t_br);
          e_dba = clip(cyc - t_bf);
          s     = e_ah + e_dab + e_bh + e_dba;
          e_per = clip(s);
          e_mv  = 1;
        end
        t_ar = cyc; phase = 1;
      end else if (phase == 1 && af) begin
        t_af = cyc; phase = 2;
      end else if (phase == 2 && br) begin
        t_br = cyc; phase = 3;
      end else if (phase == 3 && bf) begin
        t_bf = cyc; phase = 4;
      end
      e_ov = (e_ov & ~flt_clr) | both;
      e_st = (e_st & ~flt_clr) | stl;
      m_prev = cur;
    end
  end

  // ---------------- per-cycle compare + pulse monitor ----------------
  int mv_count = 0;
  int mv_last  = 0;
  int mv_gap   = 0;

  always @(negedge clk) begin
    if (ready) begin
      n_vec++;
      if (int'(a_high) != e_ah || int'(dt_ab) != e_dab || int'(b_high) != e_bh ||
          int'(dt_ba) != e_dba || int'(period) != e_per || meas_valid !== e_mv ||
          overlap_flt !== e_ov || stall_flt !== e_st) begin
        n_miss++;
        $display("FAIL model cyc=%0d got ah=%0d dab=%0d bh=%0d dba=%0d per=%0d mv=%0b ov=%0b st=%0b want ah=%0d dab=%0d bh=%0d dba=%0d per=%0d mv=%0b ov=%0b st=%0b",
                 cyc, a_high, dt_ab, b_high, dt_ba, period, meas_valid, overlap_flt, stall_flt,
                 e_ah, e_dab, e_bh, e_dba, e_per, e_mv, e_ov, e_st);
      end
      if (meas_valid === 1'b1) begin
        if (mv_last > 0) mv_gap = cyc - mv_last;
        mv_last = cyc;
        mv_count++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic seg(input logic a, input logic b, input int n);
    pwmA = a; pwmB = b;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic period_std();
    seg(1, 0, 100); seg(0, 0, 10); seg(0, 1, 80); seg(0, 0, 10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, rc;
    rst = 1; pwmA = 0; pwmB = 0; flt_clr = 0; timeout = '0;
    seg(0, 0, 3);
    chk("reset_a_high", int'(a_high), 0);
    chk("reset_period", int'(period), 0);
    chk("reset_flags", {meas_valid, overlap_flt, stall_flt}, 0);
    rst = 0;
    seg(0, 0, 5);

    // steady state
    repeat (4) period_std();
    c0 = cyc;
    seg(1, 0, 95);
    chk("steady_a_high", int'(a_high), 100);
    chk("steady_dt_ab", int'(dt_ab), 10);
    chk("steady_b_high", int'(b_high), 80);
    chk("steady_dt_ba", int'(dt_ba), 10);
    chk("steady_period", int'(period), 200);
    chk("steady_mv_count", mv_count, 4);
    chk("steady_mv_gap", mv_gap, 200);
    chk("mv_latency", mv_last, c0 + 1 + LAT);

    // shoot-through: B rises 5 cycles before A falls
    seg(1, 1, 5); seg(0, 1, 75); seg(0, 0, 20);
    chk("overlap_set", overlap_flt, 1);
    chk("overlap_no_mv", mv_count, 4);
    chk("overlap_hold_a_high", int'(a_high), 100);
    chk("overlap_hold_period", int'(period), 200);

    // set/clear collision: flt_clr lands on the edge the new overlap is seen
    seg(1, 1, 1); seg(0, 0, 2);
    flt_clr = 1; seg(0, 0, 1); flt_clr = 0;
    chk("collision_keeps_flag", overlap_flt, 1);
    seg(0, 0, 5);
    flt_clr = 1; seg(0, 0, 1); flt_clr = 0;
    chk("clear_alone", overlap_flt, 0);

    // stall with timeout=50
    timeout = W'(50);
    seg(1, 0, 5);
    c0 = cyc;
    seg(0, 0, 1 + LAT + 49);
    chk("stall_before", stall_flt, 0);
    seg(0, 0, 1);
    chk("stall_at_50", stall_flt, 1);
    chk("stall_elapsed", cyc - (c0 + 1 + LAT), 50);
    flt_clr = 1; seg(0, 0, 1); flt_clr = 0;
    chk("stall_cleared", stall_flt, 0);
    timeout = '0;
    seg(1, 0, 5); seg(0, 0, 120);
    chk("stall_disabled", stall_flt, 0);

    // saturation
    seg(1, 0, MAXV + 1 + 10); seg(0, 0, 10); seg(0, 1, 80); seg(0, 0, 10);
    seg(1, 0, 5);
    chk("sat_a_high", int'(a_high), MAXV);
    chk("sat_period", int'(period), MAXV);
    chk("sat_b_high", int'(b_high), 80);

    // reset during B_ON, then two full cycles
    seg(1, 0, 95); seg(0, 0, 10); seg(0, 1, 40);
    rst = 1; seg(0, 1, 2); rst = 0;
    rc = mv_count;
    seg(0, 1, 40); seg(0, 0, 10);
    period_std();
    period_std();
    chk("rst_mid_mv_count", mv_count - rc, 1);
    chk("rst_mid_a_high", int'(a_high), 100);
    chk("rst_mid_dt_ab", int'(dt_ab), 10);
    chk("rst_mid_b_high", int'(b_high), 80);
    chk("rst_mid_period", int'(period), 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pwm_bridge_monitor.md
PWM_BRIDGE_MONITOR -- requirements
Module: pwm_bridge_monitor

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops per PWM input (legal range 2..3).
REQ-002 SHALL have parameter CNT_W, default 21, the width of every measurement and timeout count.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port pwmA, input, 1 bit: high-side gate drive under observation, asynchronous to clk.
REQ-006 SHALL have port pwmB, input, 1 bit: low-side gate drive under observation, asynchronous to clk.
REQ-007 SHALL have port timeout, input, CNT_W bits: stall limit in clk cycles; 0 disables stall detection.
REQ-008 SHALL have port flt_clr, input, 1 bit: clears the sticky fault flags.
REQ-009 SHALL have ports a_high, dt_ab, b_high, dt_ba, period, each output, CNT_W bits: the last complete cycle's measurements.
REQ-010 SHALL have port meas_valid, output, 1 bit: one-cycle pulse when the measurement outputs update.
REQ-011 SHALL have port overlap_flt, output, 1 bit: sticky flag, A and B seen high together (shoot-through).
REQ-012 SHALL have port stall_flt, output, 1 bit: sticky flag, no input edge seen within timeout cycles.

Function
REQ-013 SHALL pass pwmA and pwmB each through SYNC_STAGES flops; all further logic SHALL use only the synchronized signals sA and sB.
REQ-014 SHALL run an FSM with states WAIT_A, A_ON, GAP_AB, B_ON and GAP_BA.
REQ-015 SHALL move WAIT_A->A_ON on an sA rise with sB low; it SHALL ignore every other event in WAIT_A.
REQ-016 SHALL make the remaining transitions as listed:
- A_ON->GAP_AB on an sA fall.
- GAP_AB->B_ON on an sB rise.
- B_ON->GAP_BA on an sB fall.
- GAP_BA->A_ON on an sA rise.
REQ-017 SHALL hold a separate CNT_W counter for each state A_ON, GAP_AB, B_ON and GAP_BA; each counter equals the number of clk cycles spent in that state.
REQ-018 SHALL, on the GAP_BA->A_ON transition, load a_high, dt_ab, b_high and dt_ba from the four counters and load period with their sum, then pulse meas_valid high for exactly 1 cycle.
REQ-019 SHALL, on the same GAP_BA->A_ON transition, restart the A_ON counter at 1 and clear the other three counters.
REQ-020 SHALL assert meas_valid on the clk edge SYNC_STAGES+1 cycles after the first edge that samples raw pwmA high.
REQ-021 SHALL saturate every counter and the period sum at 2^CNT_W-1; they SHALL NOT wrap.
REQ-022 SHALL, on an sA rise in GAP_AB (B pulse missing), go to A_ON, restart the counters and NOT assert meas_valid.
REQ-023 SHALL, whenever sA and sB are both high in any state, set overlap_flt, go to WAIT_A and NOT assert meas_valid in that cycle.
REQ-024 SHALL count clk cycles since the last sA or sB edge; when the count reaches a nonzero timeout it SHALL set stall_flt and go to WAIT_A.
REQ-025 SHALL clear overlap_flt and stall_flt on flt_clr.
REQ-026 SHALL, when a fault sets in the same cycle as flt_clr, leave that flag set.
REQ-027 SHALL hold the measurement outputs at their last values after any fault, until the next complete cycle.
REQ-028 SHALL behave normally with sA and sB as outputs of the PWM bridge generator (center-aligned, with deadtime) and of any edge-aligned source.

Reset
REQ-029 SHALL, on rst high at a clk edge, set the FSM to WAIT_A, set all counters, a_high, dt_ab, b_high, dt_ba, period, meas_valid, overlap_flt and stall_flt to 0, and set the synchronizer flops to 0.
REQ-030 SHALL let rst asserted mid-cycle abandon the partial measurement; the first meas_valid after release SHALL require a full WAIT_A->A_ON->...->A_ON sequence.

Structure
REQ-031 SHALL take CNT_W, the CNT_MAX saturation constant and the FSM state enumeration from the shared power-stage package, which the bridge generator also uses.
REQ-032 SHALL implement the synchronizer as sub-module pwm_in_sync (parameter SYNC_STAGES, 1-bit data, reset to 0), instantiated once per input.

Verification
REQ-033 SHALL cover steady state: repeat A high 100 cycles / both low 10 / B high 80 / both low 10 -> from the 2nd cycle, a_high=100, dt_ab=10, b_high=80, dt_ba=10, period=200, and meas_valid pulses every 200 cycles.
REQ-034 SHALL cover shoot-through: raise B 5 cycles before A falls -> overlap_flt=1, no meas_valid for that cycle, and outputs hold their previous values.
REQ-035 SHALL cover set/clear collision: flt_clr pulse in the same cycle as a new overlap -> overlap_flt stays 1; a later flt_clr alone -> 0.
REQ-036 SHALL cover stall: timeout=50, inputs frozen low -> stall_flt=1 exactly 50 cycles after the last edge; with timeout=0 it never sets.
REQ-037 SHALL cover saturation: A held high for 2^21+10 cycles, then a normal cycle -> a_high=0x1FFFFF and period=0x1FFFFF.
REQ-038 SHALL cover reset mid-cycle: assert rst during B_ON, release, then run 2 full cycles -> exactly 1 meas_valid, with correct values.
